// File: rtl/tc_bank.sv
// tc_bank: NUM_CH independent down-counting timers behind one word-addressed register window.
// Defining TC_PRESCALE_EN adds an 8-bit per-channel prescaler in CTRL[15:8].
module tc_bank #(
  parameter int          NUM_CH = 4,
  parameter int          CNT_W  = 32,
  parameter logic [31:0] BASE   = 32'h00007f00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [29:0]       Addr,
  input  logic              WE,
  input  logic [31:0]       Din,
  output logic [31:0]       Dout,
  output logic [NUM_CH-1:0] IRQ,
  output logic              IRQ_any
);
  // state | meaning
  // IDLE  | channel stopped, waiting for EN
  // LOAD  | copy PRESET into COUNT
  // CNT   | counting down while EN
  // INT   | expiry seen; reload (MODE 1) or stop and clear EN
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [31:0]    byte_a;
  logic [31:0]    rel;
  logic           hit;
  logic [CHW-1:0] csel;
  logic [1:0]     rsel;

  assign byte_a = {Addr, 2'b00};
  assign rel    = byte_a - BASE;
  assign hit    = (byte_a >= BASE) && (rel < 32'(16 * NUM_CH));
  assign csel   = rel[4 +: CHW];
  assign rsel   = rel[3:2];

  logic [31:0] rd_ctrl   [NUM_CH];
  logic [31:0] rd_preset [NUM_CH];
  logic [31:0] rd_count  [NUM_CH];
  logic [31:0] rd_status [NUM_CH];

  logic unused_din;
  assign unused_din = ^Din;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state;
    logic             en;
    logic             im;
    logic             pend;
    logic             step;
    logic [1:0]       mode;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic             ch_sel;
    logic             wr_ctrl;
    logic             wr_preset;
    logic             wr_status;

    assign ch_sel    = WE && hit && (csel == CHW'(i));
    assign wr_ctrl   = ch_sel && (rsel == 2'd0);
    assign wr_preset = ch_sel && (rsel == 2'd1);
    assign wr_status = ch_sel && (rsel == 2'd3);

`ifdef TC_PRESCALE_EN
    logic [7:0] presc;
    logic [7:0] pcnt;
    assign step = (pcnt == presc);
`else
    assign step = 1'b1;
`endif

    always_ff @(posedge clk) begin
      if (reset) begin
        state  <= IDLE;
        en     <= 1'b0;
        im     <= 1'b0;
        mode   <= 2'd0;
        pend   <= 1'b0;
        preset <= '0;
        count  <= '0;
`ifdef TC_PRESCALE_EN
        presc  <= 8'd0;
        pcnt   <= 8'd0;
`endif
      end else begin
        // W1C is evaluated first so an expiry on the same edge overrides it
        if (wr_status && Din[0]) pend <= 1'b0;
        case (state)
          IDLE: if (en) state <= LOAD;
          LOAD: begin
            count <= preset;
            state <= CNT;
`ifdef TC_PRESCALE_EN
            pcnt  <= 8'd0;
`endif
          end
          CNT: begin
            if (!en) begin
              state <= IDLE;
            end else if (step) begin
              if (count > CNT_W'(1)) begin
                count <= count - CNT_W'(1);
              end else begin
                count <= '0;
                pend  <= 1'b1;
                state <= INT;
              end
            end
`ifdef TC_PRESCALE_EN
            if (en) pcnt <= step ? 8'd0 : pcnt + 8'd1;
`endif
          end
          INT: begin
            if (mode == 2'd1) begin
              state <= LOAD;
            end else begin
              en    <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
        // CPU write comes last so it beats the FSM's EN clear in INT
        if (wr_ctrl) begin
          en   <= Din[0];
          mode <= Din[2:1];
          im   <= Din[3];
`ifdef TC_PRESCALE_EN
          presc <= Din[15:8];
`endif
        end
        if (wr_preset) preset <= Din[CNT_W-1:0];
      end
    end

`ifdef TC_PRESCALE_EN
    assign rd_ctrl[i] = {16'b0, presc, 4'b0, im, mode, en};
`else
    assign rd_ctrl[i] = {28'b0, im, mode, en};
`endif
    assign rd_preset[i] = 32'(preset);
    assign rd_count[i]  = 32'(count);
    assign rd_status[i] = {31'b0, pend};
    assign IRQ[i]       = pend & im;
  end

  always_comb begin
    Dout = '0;
    if (hit) begin
      case (rsel)
        2'd0:    Dout = rd_ctrl[csel];
        2'd1:    Dout = rd_preset[csel];
        2'd2:    Dout = rd_count[csel];
        default: Dout = rd_status[csel];
      endcase
    end
  end

  assign IRQ_any = |IRQ;

endmodule

// File: tb/tb_tc_bank.sv
// Self-checking bench for tc_bank: directed scenarios plus randomized channel runs
// checked against an arithmetic timing model of each channel.
module tb_tc_bank;
  localparam int          NUM_CH = 4;
  localparam int          CNT_W  = 32;
  localparam logic [31:0] BASE   = 32'h00007f00;

  logic              clk = 1'b0;
  logic              reset;
  logic [29:0]       Addr;
  logic              WE;
  logic [31:0]       Din;
  logic [31:0]       Dout;
  logic [NUM_CH-1:0] IRQ;
  logic              IRQ_any;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tc_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .BASE(BASE)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
    .Dout(Dout), .IRQ(IRQ), .IRQ_any(IRQ_any)
  );

  function automatic logic [29:0] wa(int ch, int r);
    logic [31:0] b;
    b = BASE + 32'(16 * ch + 4 * r);
    return b[31:2];
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // Write lands on the next rising edge; returns that edge's number.
  task automatic wr(int ch, int r, logic [31:0] d, output int e);
    Addr = wa(ch, r); Din = d; WE = 1'b1;
    @(posedge clk); #1;
    WE = 1'b0;
    e = cyc;
  endtask

  task automatic rd(int ch, int r, output logic [31:0] d);
    Addr = wa(ch, r); #1;
    d = Dout;
  endtask

  task automatic wait_edge(int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Model: CTRL written with EN at edge E -> LOAD state after E+1, COUNT=N after E+2,
  // one step per edge, expiry (PEND) at E+max(N,1)+2; auto-reload period max(N,1)+2.
  function automatic logic [31:0] exp_count(int n, bit reload, int k);
    int np;
    np = (n == 0) ? 1 : n;
    if (reload) k = k % (np + 2);
    return (k < np) ? 32'(n - k) : 32'd0;
  endfunction

  initial begin
    logic [31:0] d;
    int e, t0, w, f, n, np, ch, mode, p;
    bit reload;

    reset = 1'b1; WE = 1'b0; Addr = '0; Din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;

    for (int c = 0; c < NUM_CH; c++)
      for (int r = 0; r < 4; r++) begin
        rd(c, r, d);
        check($sformatf("reset_reg ch%0d r%0d", c, r), d, 32'd0);
      end
    check("reset_irq", 32'(IRQ), 32'd0);
    check("reset_irq_any", 32'(IRQ_any), 32'd0);
    wr(0, 0, 32'h9, e);
    wr(0, 0, 32'h0, e);
    rd(NUM_CH, 0, d); check("oor_above", d, 32'd0);
    rd(0, -1, d);     check("oor_below", d, 32'd0);
    wr(NUM_CH, 1, 32'h55, e);
    for (int c = 0; c < NUM_CH; c++) begin
      rd(c, 1, d); check($sformatf("oor_write ch%0d", c), d, 32'd0);
    end

    // Ch0 one-shot, PRESET=5
    wr(0, 1, 32'd5, e);
    wr(0, 0, 32'h9, t0);
    wait_edge(t0 + 2); rd(0, 2, d); check("ch0_load", d, 32'd5);
    wait_edge(t0 + 6); check("ch0_irq_early", 32'(IRQ[0]), 32'd0);
    wait_edge(t0 + 7); check("ch0_irq_set", 32'(IRQ[0]), 32'd1);
    check("ch0_irq_any", 32'(IRQ_any), 32'd1);
    wait_edge(t0 + 9);
    rd(0, 0, d); check("ch0_ctrl_after", d, 32'h8);
    rd(0, 2, d); check("ch0_count_after", d, 32'd0);
    wr(0, 3, 32'd1, e);
    check("ch0_w1c_irq", 32'(IRQ[0]), 32'd0);
    check("ch0_w1c_any", 32'(IRQ_any), 32'd0);

    // Ch2 auto-reload, PRESET=3, period 5
    wr(2, 1, 32'd3, e);
    wr(2, 0, 32'hB, t0);
    for (int k = 0; k < 4; k++) begin
      wait_edge(t0 + 4 + 5 * k); check($sformatf("ch2_pre%0d", k), 32'(IRQ[2]), 32'd0);
      wait_edge(t0 + 5 + 5 * k);
      check($sformatf("ch2_set%0d", k), 32'(IRQ[2]), 32'd1);
      check($sformatf("ch2_any%0d", k), 32'(IRQ_any), 32'd1);
      wr(2, 3, 32'd1, e);
      check($sformatf("ch2_clr%0d", k), 32'(IRQ_any), 32'd0);
    end
    wr(2, 0, 32'd0, e);
    wait_edge(e + 6); wr(2, 3, 32'd1, e);

    // Ch1 stop mid-count and restart
    wr(1, 1, 32'd100, e);
    wr(1, 0, 32'd1, t0);
    wait_edge(t0 + 2); rd(1, 2, d); check("ch1_load", d, 32'd100);
    wait_edge(t0 + 11); wr(1, 0, 32'd0, w);
    wait_edge(t0 + 15); rd(1, 2, d); check("ch1_frozen", d, 32'd90);
    wait_edge(t0 + 20); rd(1, 2, d); check("ch1_frozen2", d, 32'd90);
    wr(1, 0, 32'd1, f);
    rd(1, 2, d); check("ch1_hold_idle", d, 32'd90);
    wait_edge(f + 2); rd(1, 2, d); check("ch1_reload", d, 32'd100);
    wr(1, 0, 32'd0, e);

    // Ch3 W1C on the expiry edge, then mask
    wr(3, 1, 32'd4, e);
    wr(3, 0, 32'h9, t0);
    wait_edge(t0 + 5); wr(3, 3, 32'd1, e);
    check("ch3_race_edge", 32'(e), 32'(t0 + 6));
    check("ch3_race_irq", 32'(IRQ[3]), 32'd1);
    rd(3, 3, d); check("ch3_race_status", d, 32'd1);
    wr(3, 0, 32'h0, e);
    check("ch3_mask_irq", 32'(IRQ[3]), 32'd0);
    rd(3, 3, d); check("ch3_mask_status", d, 32'd1);
    wr(3, 3, 32'd1, e);
    rd(3, 3, d); check("ch3_clear_status", d, 32'd0);

    // Ch0 PRESET/CTRL rewrites mid-count do not restart
    wr(0, 1, 32'd6, e);
    wr(0, 0, 32'h1, t0);
    wait_edge(t0 + 3); wr(0, 1, 32'd20, e);
    wr(0, 0, 32'h9, e);
    rd(0, 2, d); check("midcount_count", d, 32'd3);
    wait_edge(t0 + 7); check("midcount_early", 32'(IRQ[0]), 32'd0);
    wait_edge(t0 + 8); check("midcount_set", 32'(IRQ[0]), 32'd1);
    wait_edge(t0 + 10); rd(0, 1, d); check("midcount_preset", d, 32'd20);
    rd(0, 0, d); check("ctrl_hi_bits", d, 32'h8);
    wr(0, 3, 32'd1, e);
    // Writing 0 to STATUS must not clear PEND
    wr(0, 1, 32'd1, e);
    wr(0, 0, 32'h9, t0);
    wait_edge(t0 + 4); wr(0, 3, 32'd0, e);
    rd(0, 3, d); check("w0_status", d, 32'd1);
    wr(0, 3, 32'd1, e);
    wr(0, 0, 32'hFFFF_FF08, e);
    rd(0, 0, d); check("ctrl_readmask", d, 32'h8);
    wr(0, 0, 32'h0, e);

    // Randomized single-channel runs
    for (int trial = 0; trial < 12; trial++) begin
      ch = int'($urandom_range(0, NUM_CH - 1));
      n = int'($urandom_range(0, 12));
      mode = int'($urandom_range(0, 3));
      reload = (mode == 1);
      np = (n == 0) ? 1 : n;
      p = np + 2;
      wr(ch, 1, 32'(n), e);
      wr(ch, 0, 32'(8 + 2 * mode + 1), t0);
      for (int t = t0 + 2; t <= t0 + 2 + 3 * p; t++) begin
        wait_edge(t);
        rd(ch, 2, d);
        check($sformatf("rnd%0d_count", trial), d, exp_count(n, reload, t - t0 - 2));
        check($sformatf("rnd%0d_irq", trial), 32'(IRQ),
              (t >= t0 + np + 2) ? (32'd1 << ch) : 32'd0);
        check($sformatf("rnd%0d_any", trial), 32'(IRQ_any), (t >= t0 + np + 2) ? 32'd1 : 32'd0);
      end
      rd(ch, 0, d);
      check($sformatf("rnd%0d_ctrl", trial), d, 32'(8 + 2 * mode + (reload ? 1 : 0)));
      wr(ch, 0, 32'd0, e);
      wait_edge(e + 6);
      wr(ch, 3, 32'd1, e);
      check($sformatf("rnd%0d_clear", trial), 32'(IRQ), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
